mult_iterative: RTL and testbench



---
 rtl/mult_pkg.sv | 32 +++
 rtl/mult_abs.sv | 36 +++
 rtl/mult_iterative.sv | 223 ++++++++++++++++++++++
 tb/tb_mult_iterative.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//
// Purpose : Shared definitions for the iterative shift-add multiplier.
//           Holds the controller state encoding, the default operand width
//           and the helper that sizes the iteration counter.
//
// Contents:
//   mult_state_t        - controller states IDLE / CALC / DONE
//   MULT_DEFAULT_WIDTH  - default operand width (32)
//   mult_cnt_width()    - counter width for a given operand width,
//                         $clog2(width+1)
//   MULT_CNT_W          - counter width for the default operand width
// -----------------------------------------------------------------------------
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   localparam int MULT_DEFAULT_WIDTH = 32;

   // The counter must be able to hold the value WIDTH itself, hence +1.
   function automatic int mult_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int MULT_CNT_W = mult_cnt_width(MULT_DEFAULT_WIDTH);

endpackage : mult_pkg

// File: rtl/mult_abs.sv
// -----------------------------------------------------------------------------
// mult_abs
//
// Purpose : Combinational magnitude / sign extractor for one multiplier
//           operand. In signed mode a negative operand is negated; the
//           magnitude is treated as an unsigned WIDTH-bit value, so the most
//           negative input -2^(WIDTH-1) maps cleanly onto 2^(WIDTH-1).
//
// Parameters:
//   WIDTH   - operand width
//   SIGNED  - 1: operand is two's complement, 0: operand is unsigned
//
// Ports:
//   operand    in  WIDTH  raw operand
//   magnitude  out WIDTH  |operand| (operand itself when unsigned)
//   sign       out 1      operand MSB in signed mode, 0 in unsigned mode
// -----------------------------------------------------------------------------
module mult_abs
   import mult_pkg::*;
#(
   parameter int WIDTH  = MULT_DEFAULT_WIDTH,
   parameter int SIGNED = 1
)
(
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] magnitude,
   output logic             sign
);

   assign sign      = (SIGNED != 0) ? operand[WIDTH-1] : 1'b0;

   // Two's-complement negation; wraps the most negative value onto itself,
   // which read as unsigned is exactly the wanted magnitude.
   assign magnitude = sign ? (~operand + {{(WIDTH-1){1'b0}}, 1'b1}) : operand;

endmodule : mult_abs

// File: rtl/mult_iterative.sv
// -----------------------------------------------------------------------------
// mult_iterative
//
// Purpose : Iterative shift-add WIDTH x WIDTH multiplier producing a full
//           2*WIDTH-bit product. Responds to a level-held mult_begin request
//           and answers with a single-cycle mult_end pulse. Operands are
//           converted to magnitudes at start, multiplied unsigned one bit per
//           clock, and the sign is re-applied on the final iteration.
//
// Parameters:
//   WIDTH   - operand width (product is 2*WIDTH bits)
//   SIGNED  - 1: two's-complement operands, 0: unsigned operands
//
// Build option:
//   MULT_EARLY_EXIT_EN - when defined, the operation finishes as soon as the
//                        remaining multiplier bits are all zero instead of
//                        always running WIDTH iterations. The product value is
//                        identical either way.
//
// Ports:
//   clk         in  1        system clock
//   reset       in  1        asynchronous, active-high reset
//   mult_begin  in  1        level request; hold high until mult_end,
//                            dropping it during CALC aborts the operation
//   mult_op1    in  WIDTH    multiplicand, sampled only at start
//   mult_op2    in  WIDTH    multiplier, sampled only at start
//   product     out 2*WIDTH  registered result, held until next completion
//   mult_end    out 1        single-cycle completion pulse
//   busy        out 1        registered, high while in CALC
// -----------------------------------------------------------------------------
module mult_iterative
   import mult_pkg::*;
#(
   parameter int WIDTH  = MULT_DEFAULT_WIDTH,
   parameter int SIGNED = 1
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mult_begin,
   input  logic [WIDTH-1:0]     mult_op1,
   input  logic [WIDTH-1:0]     mult_op2,
   output logic [2*WIDTH-1:0]   product,
   output logic                 mult_end,
   output logic                 busy
);

   localparam int CNT_W = mult_cnt_width(WIDTH);
   localparam int PW    = 2 * WIDTH;

   // ---------------------------------------------------------------------
   // Operand magnitude / sign extraction (op1 in slot 0, op2 in slot 1)
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] op_in   [2];
   logic [WIDTH-1:0] op_mag  [2];
   logic             op_sign [2];

   assign op_in[0] = mult_op1;
   assign op_in[1] = mult_op2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_abs
         mult_abs #(
            .WIDTH  (WIDTH),
            .SIGNED (SIGNED)
         ) u_abs (
            .operand   (op_in[gi]),
            .magnitude (op_mag[gi]),
            .sign      (op_sign[gi])
         );
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   mult_state_t       state_reg;
   mult_state_t       state_next;

   logic [PW-1:0]     mcand_reg;    // shifted multiplicand, double width
   logic [WIDTH-1:0]  mplr_reg;     // shifted multiplier
   logic [PW-1:0]     acc_reg;      // partial-product accumulator
   logic [CNT_W-1:0]  cnt_reg;      // iterations completed so far
   logic              sign_reg;     // sign to re-apply to the result
   logic [PW-1:0]     product_reg;
   logic              mult_end_reg;
   logic              busy_reg;

   // Control strobes from the output decoder
   logic              load;         // capture operands, start CALC
   logic              step;         // perform one shift-add iteration
   logic              finish;       // this iteration is the last one

   // ---------------------------------------------------------------------
   // One shift-add iteration
   // ---------------------------------------------------------------------
   logic [PW-1:0]     addend;
   logic [PW-1:0]     acc_sum;
   logic              last_iter;

   assign addend  = mplr_reg[0] ? mcand_reg : '0;
   // Both inputs are bounded by the magnitudes, so this cannot carry out.
   assign acc_sum = acc_reg + addend;

`ifdef MULT_EARLY_EXIT_EN
   // Stop once nothing is left to add after this step; the counter limit
   // still bounds the operation for a full-width multiplier.
   assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1)) ||
                      (mplr_reg[WIDTH-1:1] == '0);
`else
   assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
`endif

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (mult_begin) begin
               state_next = CALC;
            end
         end
         CALC: begin
            // Abort has priority over completion on the same edge.
            if (!mult_begin) begin
               state_next = IDLE;
            end else if (last_iter) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // No automatic restart: the requester must drop mult_begin.
            if (!mult_begin) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: output / control decode
   // ---------------------------------------------------------------------
   always_comb begin
      load   = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      case (state_reg)
         IDLE: begin
            load = mult_begin;
         end
         CALC: begin
            step   = mult_begin;
            finish = mult_begin && last_iter;
         end
         default: begin
            load   = 1'b0;
            step   = 1'b0;
            finish = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_reg    <= '0;
         mplr_reg     <= '0;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         sign_reg     <= 1'b0;
         product_reg  <= '0;
         mult_end_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         mult_end_reg <= finish;
         busy_reg     <= (state_next == CALC);

         if (load) begin
            mcand_reg <= {{WIDTH{1'b0}}, op_mag[0]};
            mplr_reg  <= op_mag[1];
            sign_reg  <= op_sign[0] ^ op_sign[1];
            acc_reg   <= '0;
            cnt_reg   <= '0;
         end else if (step) begin
            acc_reg   <= acc_sum;
            mcand_reg <= {mcand_reg[PW-2:0], 1'b0};
            mplr_reg  <= {1'b0, mplr_reg[WIDTH-1:1]};
            cnt_reg   <= cnt_reg + CNT_W'(1);
         end

         // The final addend is folded in here rather than waiting one more
         // edge for the accumulator to settle.
         if (finish) begin
            product_reg <= sign_reg ? (~acc_sum + {{(PW-1){1'b0}}, 1'b1})
                                    : acc_sum;
         end
      end
   end

   assign product  = product_reg;
   assign mult_end = mult_end_reg;
   assign busy     = busy_reg;

endmodule : mult_iterative

// File: tb/tb_mult_iterative.sv
// -----------------------------------------------------------------------------
// tb_mult_iterative
//
// Self-checking bench for mult_iterative. Two instances share the stimulus:
// one signed (SIGNED=1), one unsigned (SIGNED=0). Expected products come from
// plain 64-bit arithmetic, expected latency from the operand's bit length.
// Latency is counted in clock edges including the edge that samples
// mult_begin, i.e. the 1-based index of the edge after which mult_end is
// first seen high.
// -----------------------------------------------------------------------------
module tb_mult_iterative;

   localparam int W = 32;

   logic            clk;
   logic            reset;
   logic            mult_begin;
   logic [W-1:0]    op1;
   logic [W-1:0]    op2;

   logic [2*W-1:0]  s_product;
   logic            s_end;
   logic            s_busy;
   logic [2*W-1:0]  u_product;
   logic            u_end;
   logic            u_busy;

   int checks = 0;
   int errors = 0;

   mult_iterative #(.WIDTH(W), .SIGNED(1)) dut_s (
      .clk        (clk),
      .reset      (reset),
      .mult_begin (mult_begin),
      .mult_op1   (op1),
      .mult_op2   (op2),
      .product    (s_product),
      .mult_end   (s_end),
      .busy       (s_busy)
   );

   mult_iterative #(.WIDTH(W), .SIGNED(0)) dut_u (
      .clk        (clk),
      .reset      (reset),
      .mult_begin (mult_begin),
      .mult_op1   (op1),
      .mult_op2   (op2),
      .product    (u_product),
      .mult_end   (u_end),
      .busy       (u_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   function automatic logic [63:0] ref_prod(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input bit sgn);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic [63:0] ua;
      logic [63:0] ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (sgn) return 64'(sa * sb);
      return ua * ub;
   endfunction

   function automatic int ref_lat(input logic [31:0] b, input bit sgn);
      logic [31:0] m;
      int hi;
      m  = (sgn && b[31]) ? (32'd0 - b) : b;
      hi = -1;
      for (int i = 0; i < 32; i++) if (m[i]) hi = i;
`ifdef MULT_EARLY_EXIT_EN
      if (hi < 0) return 2;
      return hi + 2;
`else
      return W + 1;
`endif
   endfunction

   // ---------------------------------------------------------------------
   // Run one complete operation with mult_begin held; drops it afterwards.
   // ---------------------------------------------------------------------
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] ps, output logic [63:0] pu,
                         output int lat_s, output int lat_u,
                         output int np_s, output int np_u,
                         output logic busy0, output logic busy_done);
      @(negedge clk);
      op1 = a;
      op2 = b;
      mult_begin = 1'b1;
      lat_s = -1; lat_u = -1; np_s = 0; np_u = 0; busy0 = 1'b0;
      for (int e = 1; e <= W + 4; e++) begin
         @(posedge clk);
         #1;
         if (e == 1) busy0 = s_busy & u_busy;
         if (s_end) begin np_s++; if (lat_s < 0) lat_s = e; end
         if (u_end) begin np_u++; if (lat_u < 0) lat_u = e; end
      end
      ps = s_product;
      pu = u_product;
      busy_done = s_busy | u_busy;
      @(negedge clk);
      mult_begin = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      mult_begin = 1'b0;
      op1 = '0;
      op2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_product !== 64'd0 || u_product !== 64'd0) begin
         errors++;
         $display("FAIL reset_product: got s=%h u=%h expected 0", s_product, u_product);
      end
      checks++;
      if (s_end !== 1'b0 || u_end !== 1'b0 || s_busy !== 1'b0 || u_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got end=%b%b busy=%b%b expected 0", s_end, u_end, s_busy, u_busy);
      end
      reset = 1'b0;
      @(negedge clk);
      $display("reset: product s=%h u=%h", s_product, u_product);
   endtask

   task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ps, pu, es, eu;
      int ls, lu, ns, nu;
      logic b0, bd;
      run_op(a, b, ps, pu, ls, lu, ns, nu, b0, bd);
      es = ref_prod(a, b, 1'b1);
      eu = ref_prod(a, b, 1'b0);
      $display("%s: a=%h b=%h s=%h u=%h lat=%0d/%0d pulses=%0d/%0d",
               name, a, b, ps, pu, ls, lu, ns, nu);
      checks++;
      if (ps !== es) begin
         errors++;
         $display("FAIL %s_signed_product: got %h expected %h", name, ps, es);
      end
      checks++;
      if (pu !== eu) begin
         errors++;
         $display("FAIL %s_unsigned_product: got %h expected %h", name, pu, eu);
      end
      checks++;
      if (ls != ref_lat(b, 1'b1) || lu != ref_lat(b, 1'b0)) begin
         errors++;
         $display("FAIL %s_latency: got %0d/%0d expected %0d/%0d", name, ls, lu,
                  ref_lat(b, 1'b1), ref_lat(b, 1'b0));
      end
      checks++;
      if (ns != 1 || nu != 1) begin
         errors++;
         $display("FAIL %s_pulses: got %0d/%0d expected 1/1", name, ns, nu);
      end
      checks++;
      if (b0 !== 1'b1 || bd !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy: got start=%b done=%b expected 1/0", name, b0, bd);
      end
   endtask

   task automatic test_directed();
      logic [31:0] ta [8];
      logic [31:0] tb [8];
      logic [63:0] ts [8];
      logic [63:0] ps, pu;
      int ls, lu, ns, nu;
      logic b0, bd;
      ta[0] = 32'd7;          tb[0] = 32'd6;          ts[0] = 64'd42;
      ta[1] = 32'hFFFFFFFD;   tb[1] = 32'd5;          ts[1] = 64'hFFFFFFFF_FFFFFFF1;
      ta[2] = 32'h80000000;   tb[2] = 32'h80000000;   ts[2] = 64'h40000000_00000000;
      ta[3] = 32'hFFFFFFFF;   tb[3] = 32'hFFFFFFFF;   ts[3] = 64'd1;
      ta[4] = 32'hFFFFFFF0;   tb[4] = 32'd0;          ts[4] = 64'd0;
      ta[5] = 32'd0;          tb[5] = 32'hFFFFFFFB;   ts[5] = 64'd0;
      ta[6] = 32'h12345678;   tb[6] = 32'd1;          ts[6] = 64'h00000000_12345678;
      ta[7] = 32'hFFFFFFFE;   tb[7] = 32'h10;         ts[7] = 64'hFFFFFFFF_FFFFFFE0;
      for (int i = 0; i < 8; i++) begin
         check_op("directed", ta[i], tb[i]);
      end
      // Spot constants independent of the model
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, ps, pu, ls, lu, ns, nu, b0, bd);
      checks++;
      if (pu !== 64'hFFFFFFFE_00000001 || ps !== ts[3]) begin
         errors++;
         $display("FAIL const_all_ones: got s=%h u=%h expected s=%h u=fffffffe00000001", ps, pu, ts[3]);
      end
      for (int i = 0; i < 8; i += 7) begin
         run_op(ta[i], tb[i], ps, pu, ls, lu, ns, nu, b0, bd);
         checks++;
         if (ps !== ts[i]) begin
            errors++;
            $display("FAIL const_signed_%0d: got %h expected %h", i, ps, ts[i]);
         end
      end
`ifdef MULT_EARLY_EXIT_EN
      run_op(32'd3, 32'd1, ps, pu, ls, lu, ns, nu, b0, bd);
      checks++;
      if (ls != 2) begin
         errors++;
         $display("FAIL early_exit_op2_1: got %0d expected 2", ls);
      end
      run_op(32'd3, 32'h10, ps, pu, ls, lu, ns, nu, b0, bd);
      checks++;
      if (ls != 6) begin
         errors++;
         $display("FAIL early_exit_op2_10: got %0d expected 6", ls);
      end
`else
      run_op(32'd7, 32'd6, ps, pu, ls, lu, ns, nu, b0, bd);
      checks++;
      if (ls != 33) begin
         errors++;
         $display("FAIL fixed_latency: got %0d expected 33", ls);
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         case (i % 4)
            0:       b = $urandom_range(0, 300);
            1:       b = 32'd0 - $urandom_range(1, 300);
            default: b = $urandom;
         endcase
         check_op("random", a, b);
      end
   endtask

   task automatic test_abort();
      logic [63:0] ps, pu, prev_s, prev_u;
      int ls, lu, ns, nu, pulses;
      logic b0, bd;
      run_op(32'd2, 32'd3, ps, pu, ls, lu, ns, nu, b0, bd);
      prev_s = 64'd6;
      prev_u = 64'd6;
      pulses = 0;
      @(negedge clk);
      op1 = 32'd9;
      op2 = 32'd9;
      mult_begin = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (s_end || u_end) pulses++;
      end
      @(negedge clk);
      mult_begin = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (s_busy !== 1'b0 || u_busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy: got %b/%b expected 0/0", s_busy, u_busy);
      end
      repeat (W + 4) begin
         @(posedge clk);
         #1;
         if (s_end || u_end) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL abort_no_end: got %0d pulses expected 0", pulses);
      end
      checks++;
      if (s_product !== prev_s || u_product !== prev_u) begin
         errors++;
         $display("FAIL abort_product_kept: got s=%h u=%h expected %h", s_product, u_product, prev_s);
      end
      $display("abort: product s=%h u=%h pulses=%0d", s_product, u_product, pulses);
      run_op(32'd9, 32'd9, ps, pu, ls, lu, ns, nu, b0, bd);
      checks++;
      if (ps !== 64'd81 || pu !== 64'd81 || ns != 1) begin
         errors++;
         $display("FAIL abort_restart: got s=%h u=%h pulses=%0d expected 81 with 1 pulse", ps, pu, ns);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] ps, pu;
      int ls, lu, ns, nu;
      logic b0, bd;
      @(negedge clk);
      op1 = 32'd1234;
      op2 = 32'd5678;
      mult_begin = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (s_product !== 64'd0 || u_product !== 64'd0 || s_end !== 1'b0 ||
          s_busy !== 1'b0 || u_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got s=%h u=%h end=%b busy=%b%b expected all 0",
                  s_product, u_product, s_end, s_busy, u_busy);
      end
      mult_begin = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      $display("reset_mid: product s=%h busy=%b", s_product, s_busy);
      run_op(32'hDEADBEEF, 32'd0, ps, pu, ls, lu, ns, nu, b0, bd);
      checks++;
      if (ps !== 64'd0 || pu !== 64'd0 || ns != 1) begin
         errors++;
         $display("FAIL after_reset_zero: got s=%h u=%h pulses=%0d expected 0 with 1 pulse", ps, pu, ns);
      end
   endtask

   task automatic test_hold();
      logic [31:0] a, b;
      logic [63:0] es, ps, pu;
      int pulses, ls, lu, ns, nu;
      logic b0, bd, changed;
      a = 32'hFFFF1234;
      b = 32'h00ABCDEF;
      es = ref_prod(a, b, 1'b1);
      pulses = 0;
      changed = 1'b0;
      @(negedge clk);
      op1 = a;
      op2 = b;
      mult_begin = 1'b1;
      for (int e = 1; e <= W + 101; e++) begin
         @(posedge clk);
         #1;
         if (s_end) pulses++;
         if (e > W + 1 && s_product !== es) changed = 1'b1;
         @(negedge clk);
         op1 = $urandom;
         op2 = $urandom;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL hold_pulses: got %0d expected 1", pulses);
      end
      checks++;
      if (changed || s_product !== es) begin
         errors++;
         $display("FAIL hold_product: got %h expected %h stable", s_product, es);
      end
      $display("hold: product=%h pulses=%0d", s_product, pulses);
      mult_begin = 1'b0;
      @(posedge clk);
      run_op(32'd100, 32'hFFFFFFF6, ps, pu, ls, lu, ns, nu, b0, bd);
      checks++;
      if (ps !== 64'hFFFFFFFF_FFFFFC18 || ns != 1) begin
         errors++;
         $display("FAIL hold_restart: got %h pulses=%0d expected fffffffffffffc18 with 1 pulse", ps, ns);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_reset_mid();
      test_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule : tb_mult_iterative
